// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_pkg                                                      |
// | Description : Shared state encoding and bus-level constants for i2c_slave |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_line_sync                                                |
// | Description : 2-flop synchroniser, optional 3-sample majority filter       |
// |               (I2C_SLAVE_GLITCH_FILTER_EN) and rise/fall edge flags        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    // Idle bus is high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_line};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    // Two of three samples must agree, so a single-clk pulse never passes.
    assign w_level = (r_sync[1] & r_hist[0]) |
                     (r_sync[1] & r_hist[1]) |
                     (r_hist[0] & r_hist[1]);
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_slave                                                    |
// | Description : Oversampled 7-bit-address I2C slave with byte read/write     |
// |               interface; glitch filter via I2C_SLAVE_GLITCH_FILTER_EN      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_rd_path;
    logic [7:0] w_rx_byte;

    i2c_state_t r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_cnt_nxt;
    logic [6:0] r_shift, w_shift_nxt;
    logic [6:0] r_tx_shift, w_tx_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_busy, w_busy_nxt;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (scl),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (sda),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start   = w_sda_fall & w_scl_lvl;
    assign w_stop    = w_sda_rise & w_scl_lvl;
    assign w_rx_byte = {r_shift, w_sda_lvl};
    assign w_rd_path = (r_state == ADDR_ACK) && (r_rw == RW_READ);

    // In ACK states bit_cnt 0 means "before the ACK-slot rise", 1 means "after".
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_tx_shift_nxt = r_tx_shift;
        w_rw_nxt       = r_rw;
        w_sda_low_nxt  = r_sda_low;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_busy_nxt     = r_busy;

        if (w_stop) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = 3'd0;
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = ADDR;
            w_cnt_nxt     = 3'd0;
            w_sda_low_nxt = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte[6:0];
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt = 3'd0;
                            if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                                w_state_nxt = ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_rx_byte[0];
                            end else begin
                                w_state_nxt = WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (w_scl_fall && (r_bit_cnt == 3'd0)) begin
                        w_sda_low_nxt = 1'b1;
                    end else if (w_scl_rise) begin
                        w_cnt_nxt    = 3'd1;
                        w_tx_req_nxt = w_rd_path;
                    end else if (w_scl_fall) begin
                        w_cnt_nxt = 3'd0;
                        if (w_rd_path) begin
                            w_state_nxt    = RD_DATA;
                            w_tx_shift_nxt = tx_data[6:0];
                            w_sda_low_nxt  = ~tx_data[7];
                        end else begin
                            w_state_nxt   = WR_DATA;
                            w_sda_low_nxt = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte[6:0];
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt      = 3'd0;
                            w_state_nxt    = WR_ACK;
                            w_rx_data_nxt  = w_rx_byte;
                            w_rx_valid_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = RD_ACK;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_sda_low_nxt  = ~r_tx_shift[6];
                        w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
                    end
                end
                RD_ACK: begin
                    if (w_scl_fall && (r_bit_cnt == 3'd0)) begin
                        w_sda_low_nxt = 1'b0;
                    end else if (w_scl_rise) begin
                        if (w_sda_lvl == NACK) begin
                            w_state_nxt = WAIT_STOP;
                        end else begin
                            w_cnt_nxt    = 3'd1;
                            w_tx_req_nxt = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        w_cnt_nxt      = 3'd0;
                        w_state_nxt    = RD_DATA;
                        w_tx_shift_nxt = tx_data[6:0];
                        w_sda_low_nxt  = ~tx_data[7];
                    end
                end
                default: begin
                    w_sda_low_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_tx_shift <= 7'd0;
            r_rw       <= 1'b0;
            r_sda_low  <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_sda_low  <= w_sda_low_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Gating with rst_n releases the line the instant reset asserts.
    assign sda      = (r_sda_low && rst_n) ? 1'b0 : 1'bz;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_slave                                                 |
// | Description : Self-checking bench for i2c_slave: bit-banged master, table  |
// |               of write transactions plus read/restart/glitch/reset cases   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_slave;
    import i2c_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       scl_o;
    logic       m_low;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    wire        sda_bus;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave #(.SLAVE_ADDR(7'h33)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl_o),
        .sda      (sda_bus),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         rx_cnt = 0;
    int         tx_req_cnt = 0;
    int         tx_idx = 0;
    logic [7:0] rx_cap [4];
    logic [7:0] tx_bytes [4];
    logic       dut_low_seen = 1'b0;

    always @(posedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 4) rx_cap[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (tx_req) tx_req_cnt++;
        if (!m_low && sda_bus === 1'b0) dut_low_seen = 1'b1;
    end

    always @(negedge clk) begin
        if (tx_req) begin
            tx_data = tx_bytes[tx_idx];
            tx_idx  = (tx_idx + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        tick(2); m_low = 1'b0;
        tick(2); scl_o = 1'b1;
        tick(4); m_low = 1'b1;
        tick(4); scl_o = 1'b0;
        tick(2);
    endtask

    task automatic i2c_stop();
        tick(2); m_low = 1'b1;
        tick(3); scl_o = 1'b1;
        tick(4); m_low = 1'b0;
        tick(4);
    endtask

    task automatic send_bit(input logic b);
        tick(2); m_low = ~b;
        tick(3); scl_o = 1'b1;
        tick(5); scl_o = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tick(2); m_low = 1'b0;
        tick(3); scl_o = 1'b1;
        tick(3); b = (sda_bus !== 1'b0);
        tick(2); scl_o = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(master_ack);
    endtask

    typedef struct {
        string      name;
        logic [7:0] addr_byte;
        int         n_data;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        logic       exp_busy;
        int         exp_rxv;
        logic [7:0] exp_rx_last;
        logic       exp_drive;
    } wr_vec_t;

    wr_vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         exp_cnt;

        vecs[0] = '{"wr_two",   8'h66, 2, 8'hA6, 8'h3C, 1'b0, 1'b1, 2, 8'h3C, 1'b1};
        vecs[1] = '{"miss_44",  8'h44, 1, 8'h12, 8'h00, 1'b1, 1'b0, 0, 8'h3C, 1'b0};
        vecs[2] = '{"wr_00",    8'h66, 1, 8'h00, 8'h00, 1'b0, 1'b1, 1, 8'h00, 1'b1};
        vecs[3] = '{"miss_e6",  8'hE6, 1, 8'h55, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[4] = '{"wr_ff",    8'h66, 1, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 8'hFF, 1'b1};
        vecs[5] = '{"miss_32",  8'h32, 1, 8'hAA, 8'h00, 1'b1, 1'b0, 0, 8'hFF, 1'b0};

        rst_n = 1'b0; scl_o = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        tick(4);
        check("rst_state",    32'(dut.r_state), 32'(IDLE));
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_tx_req",   32'(tx_req), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data), 32'h00);
        check("rst_sda",      32'(sda_bus), 32'd1);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            rx_cnt = 0; dut_low_seen = 1'b0;
            i2c_start();
            write_byte(vecs[i].addr_byte, ack);
            check({vecs[i].name, "_addr_ack"}, 32'(ack), 32'(vecs[i].exp_ack));
            check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].exp_busy));
            write_byte(vecs[i].d0, ack);
            check({vecs[i].name, "_d0_ack"}, 32'(ack), 32'(vecs[i].exp_ack));
            if (vecs[i].n_data > 1) begin
                write_byte(vecs[i].d1, ack);
                check({vecs[i].name, "_d1_ack"}, 32'(ack), 32'(vecs[i].exp_ack));
            end
            check({vecs[i].name, "_busy_pre_stop"}, 32'(busy), 32'(vecs[i].exp_busy));
            i2c_stop();
            check({vecs[i].name, "_busy_post_stop"}, 32'(busy), 32'd0);
            check({vecs[i].name, "_rxv_cnt"}, 32'(rx_cnt), 32'(vecs[i].exp_rxv));
            if (vecs[i].exp_rxv > 0) check({vecs[i].name, "_rx0"}, 32'(rx_cap[0]), 32'(vecs[i].d0));
            if (vecs[i].exp_rxv > 1) check({vecs[i].name, "_rx1"}, 32'(rx_cap[1]), 32'(vecs[i].d1));
            check({vecs[i].name, "_rx_data"}, 32'(rx_data), 32'(vecs[i].exp_rx_last));
            check({vecs[i].name, "_drive"}, 32'(dut_low_seen), 32'(vecs[i].exp_drive));
            tick(5);
        end

        // Read: two bytes, master ACKs the first and NACKs the second.
        tx_bytes[0] = 8'hD6; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'hFF; tx_bytes[3] = 8'hFF;
        tx_idx = 0; tx_req_cnt = 0;
        i2c_start();
        write_byte(8'h67, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, d);
        check("rd_byte0", 32'(d), 32'hD6);
        read_byte(1'b1, d);
        check("rd_byte1", 32'(d), 32'h5A);
        tick(4);
        check("rd_released", 32'(sda_bus), 32'd1);
        check("rd_wait_stop", 32'(dut.r_state), 32'(WAIT_STOP));
        check("rd_tx_req_cnt", 32'(tx_req_cnt), 32'd2);
        check("rd_busy", 32'(busy), 32'd1);
        i2c_stop();
        check("rd_busy_post_stop", 32'(busy), 32'd0);
        check("rd_idle", 32'(dut.r_state), 32'(IDLE));
        tick(5);

        // Repeated START in the middle of a write byte.
        tx_bytes[0] = 8'hC3; tx_idx = 0; rx_cnt = 0;
        i2c_start();
        write_byte(8'h66, ack);
        check("rs_addr_ack", 32'(ack), 32'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        check("rs_state_addr", 32'(dut.r_state), 32'(ADDR));
        for (int i = 7; i >= 0; i--) send_bit(d8_67(i));
        check("rs_state_addr_ack", 32'(dut.r_state), 32'(ADDR_ACK));
        check("rs_no_rxv", 32'(rx_cnt), 32'd0);
        read_bit(ack);
        check("rs_ack", 32'(ack), 32'd0);
        read_byte(1'b1, d);
        check("rs_rd_byte", 32'(d), 32'hC3);
        i2c_stop();
        tick(5);

        // Single-clk low glitch on scl while scl is high in WR_DATA.
        i2c_start();
        write_byte(8'h66, ack);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        tick(2); m_low = 1'b0;
        tick(3); scl_o = 1'b1;
        tick(5);
        check("gl_cnt_before", 32'(dut.r_bit_cnt), 32'd4);
        scl_o = 1'b0; tick(1); scl_o = 1'b1;
        tick(6);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_cnt = 4;
`else
        exp_cnt = 5;
`endif
        check("gl_cnt_after", 32'(dut.r_bit_cnt), 32'(exp_cnt));
        scl_o = 1'b0;
        i2c_stop();
        tick(5);

        // Reset while the slave drives bit 0 of 0x00.
        tx_bytes[0] = 8'h00; tx_idx = 0;
        i2c_start();
        write_byte(8'h67, ack);
        for (int i = 0; i < 7; i++) read_bit(ack);
        tick(5);
        check("rr_pre_drive", 32'(sda_bus), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rr_sda_hiz", 32'(sda_bus), 32'd1);
        check("rr_state", 32'(dut.r_state), 32'(IDLE));
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_rx_data", 32'(rx_data), 32'h00);
        check("rr_tx_req", 32'(tx_req), 32'd0);
        check("rr_rx_valid", 32'(rx_valid), 32'd0);
        tick(3);
        rst_n = 1'b1;
        dut_low_seen = 1'b0;
        read_bit(ack);
        send_bit(1'b1);
        send_bit(1'b0);
        check("rr_ignore_state", 32'(dut.r_state), 32'(IDLE));
        check("rr_ignore_drive", 32'(dut_low_seen), 32'd0);
        i2c_stop();
        rx_cnt = 0;
        i2c_start();
        write_byte(8'h66, ack);
        check("rr_new_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h81, ack);
        check("rr_new_rx", 32'(rx_data), 32'h81);
        i2c_stop();
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic d8_67(input int i);
        logic [7:0] v;
        v = 8'h67;
        return v[i];
    endfunction

endmodule
`default_nettype wire
